mem_stage_ctrl: RTL and testbench

- MEM-stage controller that sits directly downstream of the EX/MEM pipeline register and drives the MEM/WB writeback signals.
- Performs loads and stores through a request/acknowledge data-memory port and stalls upstream stages while an access is outstanding.
- Selects the writeback data (load data or ALU result) and registers it with its destination register address and write enable.
- Inserts bubbles into writeback while the pipeline is stalled.

---
 rtl/mem_stage_ctrl_if.sv | 20 ++
 rtl/mem_stage_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge port of the MEM-stage controller.
// master: the controller (issues requests); slave: the data memory.
interface mem_stage_ctrl_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues loads/stores over a req/ack data port,
// stalls upstream while an access is outstanding, and registers the
// MEM/WB writeback (data, destination, write enable).
// Optional feature macro: MEM_TIMEOUT_EN (access timeout + sticky err_o).
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [31:0]          alu_result_i,
  input  logic [31:0]          memwrite_data_i,
  input  logic [4:0]           rd_addr_i,
  input  logic                 regwrite_i,
  input  logic                 memtoreg_i,
  input  logic                 memread_i,
  input  logic                 memwrite_i,
  output logic                 stall_o,
  mem_stage_ctrl_if.master     dmem,
  output logic [31:0]          wb_data_o,
  output logic [4:0]           wb_rd_addr_o,
  output logic                 wb_regwrite_o
`ifdef MEM_TIMEOUT_EN
  ,
  output logic                 err_o
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        regwrite_q, regwrite_d;
  logic        memtoreg_q, memtoreg_d;
  logic        we_q, we_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_regwrite_q, wb_regwrite_d;

  logic mem_op;
  logic ack;
  logic tmo;

  assign mem_op = memread_i | memwrite_i;
  // ack only has meaning while a request is outstanding
  assign ack    = (state_q == BUSY) & dmem.dmem_ack;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  // cnt_q counts BUSY cycles already spent without ack; the cycle in which
  // the waited total reaches TIMEOUT_CYCLES is the abort cycle. Ack wins.
  assign tmo   = (state_q == BUSY) & ~dmem.dmem_ack &
                 (cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign err_o = err_q;
`else
  logic unused_tmo_cfg;
  assign tmo            = 1'b0;
  assign unused_tmo_cfg = ^8'(TIMEOUT_CYCLES);
`endif

  assign dmem.dmem_req   = (state_q == BUSY);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  assign wb_data_o     = wb_data_q;
  assign wb_rd_addr_o  = wb_rd_q;
  assign wb_regwrite_o = wb_regwrite_q;

  // Next-state, latch/writeback selection and stall; start_i gates the commit only
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rd_d          = rd_q;
    regwrite_d    = regwrite_q;
    memtoreg_d    = memtoreg_q;
    we_d          = we_q;
    wb_data_d     = wb_data_q;
    wb_rd_d       = wb_rd_q;
    wb_regwrite_d = wb_regwrite_q;
    stall_o       = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d         = cnt_q;
    err_d         = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall_o       = 1'b1;
          addr_d        = alu_result_i;
          wdata_d       = memwrite_data_i;
          rd_d          = rd_addr_i;
          regwrite_d    = regwrite_i;
          memtoreg_d    = memtoreg_i;
          we_d          = memwrite_i;   // read+write together is a store
          wb_regwrite_d = 1'b0;         // bubble
          state_d       = BUSY;
`ifdef MEM_TIMEOUT_EN
          cnt_d         = 8'd0;
`endif
        end else begin
          wb_data_d     = alu_result_i;
          wb_rd_d       = rd_addr_i;
          wb_regwrite_d = regwrite_i;
        end
      end
      BUSY: begin
        if (ack) begin
          wb_data_d     = memtoreg_q ? dmem.dmem_rdata : addr_q;
          wb_rd_d       = rd_q;
          wb_regwrite_d = regwrite_q;
          state_d       = IDLE;
        end else if (tmo) begin
          wb_regwrite_d = 1'b0;         // instruction dropped
          state_d       = IDLE;
`ifdef MEM_TIMEOUT_EN
          err_d         = 1'b1;
`endif
        end else begin
          stall_o       = 1'b1;
          wb_regwrite_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
          cnt_d         = cnt_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State/latch/WB registers; everything holds while start_i is low
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_q          <= '0;
      regwrite_q    <= 1'b0;
      memtoreg_q    <= 1'b0;
      we_q          <= 1'b0;
      wb_data_q     <= '0;
      wb_rd_q       <= '0;
      wb_regwrite_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else if (start_i) begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rd_q          <= rd_d;
      regwrite_q    <= regwrite_d;
      memtoreg_q    <= memtoreg_d;
      we_q          <= we_d;
      wb_data_q     <= wb_data_d;
      wb_rd_q       <= wb_rd_d;
      wb_regwrite_q <= wb_regwrite_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q         <= cnt_d;
      err_q         <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: table of instructions driven
// through a scoreboard, plus hand-written start/reset/timeout sequences.
module tb_mem_stage_ctrl;
`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] alu, wdata;
  logic [4:0]  rd;
  logic        rw, m2r, mrd, mwr;
  logic        stall;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_rw;
`ifdef MEM_TIMEOUT_EN
  logic        err;
`endif

  mem_stage_ctrl_if dif ();

  mem_stage_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i           (clk),
    .rst_i           (rst_n),
    .start_i         (start),
    .alu_result_i    (alu),
    .memwrite_data_i (wdata),
    .rd_addr_i       (rd),
    .regwrite_i      (rw),
    .memtoreg_i      (m2r),
    .memread_i       (mrd),
    .memwrite_i      (mwr),
    .stall_o         (stall),
    .dmem            (dif),
    .wb_data_o       (wb_data),
    .wb_rd_addr_o    (wb_rd),
    .wb_regwrite_o   (wb_rw)
`ifdef MEM_TIMEOUT_EN
    ,
    .err_o           (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, wdata, rdata;
    logic [4:0]  rd;
    logic        rw, m2r, mrd, mwr;
    int          ack_cyc;         // BUSY cycle (1-based) carrying ack; 0 = no mem op
    logic [31:0] e_data;
    logic [4:0]  e_rd;
    logic        e_rw;
    int          e_stall;
    int          e_req;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  rd;
    logic        rw;
  } wb_t;

  wb_t  sbq[$];
  vec_t tbl[6];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r,
                              input logic w, input logic m, input logic rdq, input logic wr,
                              input int ac, input logic [31:0] rdat, input logic [31:0] ed,
                              input logic [4:0] er, input logic ew, input int es, input int eq);
    vec_t v;
    v.alu = a; v.wdata = wd; v.rd = r; v.rw = w; v.m2r = m; v.mrd = rdq; v.mwr = wr;
    v.ack_cyc = ac; v.rdata = rdat; v.e_data = ed; v.e_rd = er; v.e_rw = ew;
    v.e_stall = es; v.e_req = eq;
    return v;
  endfunction

  task automatic idle_inputs();
    alu = '0; wdata = '0; rd = '0; rw = 0; m2r = 0; mrd = 0; mwr = 0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r,
                       input logic w, input logic m, input logic rdq, input logic wr);
    alu = a; wdata = wd; rd = r; rw = w; m2r = m; mrd = rdq; mwr = wr;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int  stalls, reqs;
    bit  bus_ok, bub_ok, done;
    wb_t e;
    @(negedge clk);
    drive(v.alu, v.wdata, v.rd, v.rw, v.m2r, v.mrd, v.mwr);
    start = 1'b1;
    sbq.push_back('{v.e_data, v.e_rd, v.e_rw});
    stalls = 0; reqs = 0; bus_ok = 1; bub_ok = 1; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (c > 0) @(negedge clk);
      dif.dmem_ack   = (v.ack_cyc != 0) && (c == v.ack_cyc);
      dif.dmem_rdata = dif.dmem_ack ? v.rdata : 32'h0BAD_0BAD;
      #1;
      if (stall) stalls++;
      if (dif.dmem_req) begin
        reqs++;
        if (dif.dmem_addr !== v.alu || dif.dmem_we !== v.mwr ||
            (v.mwr && dif.dmem_wdata !== v.wdata)) bus_ok = 0;
      end
      if (c > 0 && wb_rw !== 1'b0) bub_ok = 0;
      @(posedge clk);
      if (v.ack_cyc == 0 || dif.dmem_ack) done = 1;
    end
    #1;
    e = sbq.pop_front();
    chk({tag, "_wb_data"},  wb_data, e.d);
    chk({tag, "_wb_rd"},    32'(wb_rd), 32'(e.rd));
    chk({tag, "_wb_rw"},    32'(wb_rw), 32'(e.rw));
    chk({tag, "_stalls"},   32'(stalls), 32'(v.e_stall));
    chk({tag, "_req_cyc"},  32'(reqs), 32'(v.e_req));
    chk({tag, "_bus"},      32'(bus_ok), 32'd1);
    chk({tag, "_bubble"},   32'(bub_ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    //            alu           wdata       rd  rw m2r rd wr ack rdata         e_data        e_rd e_rw st rq
    tbl[0] = mk(32'h0000_0010, 32'h0,      5,  1, 0, 0, 0, 0, 32'h0,        32'h0000_0010, 5,  1, 0, 0);
    tbl[1] = mk(32'h0000_0100, 32'h0,      7,  1, 1, 1, 0, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 7,  1, 3, 3);
    tbl[2] = mk(32'h0000_0200, 32'h1234,   12, 0, 0, 0, 1, 1, 32'h0,        32'h0000_0200, 12, 0, 1, 1);
    tbl[3] = mk(32'hFFFF_FFFF, 32'h0,      31, 0, 0, 0, 0, 0, 32'h0,        32'hFFFF_FFFF, 31, 0, 0, 0);
    tbl[4] = mk(32'h0000_0300, 32'hCAFE,   3,  1, 0, 1, 1, 2, 32'h1111_1111, 32'h0000_0300, 3,  1, 2, 2);
    tbl[5] = mk(32'h0000_0104, 32'h0,      1,  1, 1, 1, 0, 1, 32'h0000_00A5, 32'h0000_00A5, 1,  1, 1, 1);

    // reset state, checked before any clock edge
    rst_n = 1'b0; start = 1'b0; idle_inputs();
    dif.dmem_ack = 1'b0; dif.dmem_rdata = '0;
    #2;
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_rd",   32'(wb_rd), 32'h0);
    chk("rst_wb_rw",   32'(wb_rw), 32'h0);
    chk("rst_req",     32'(dif.dmem_req), 32'h0);
    chk("rst_we",      32'(dif.dmem_we), 32'h0);
    chk("rst_addr",    dif.dmem_addr, 32'h0);
    chk("rst_wdata",   dif.dmem_wdata, 32'h0);
    chk("rst_stall",   32'(stall), 32'h0);
`ifdef MEM_TIMEOUT_EN
    chk("rst_err",     32'(err), 32'h0);
`endif
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // start_i dropped in BUSY with ack held: nothing moves until start returns
    @(negedge clk);
    drive(32'h0000_0040, 32'h0, 5'd9, 1, 1, 1, 0);
    start = 1'b1; dif.dmem_ack = 1'b0;
    @(posedge clk); #1;
    chk("sd_enter_req", 32'(dif.dmem_req), 32'h1);
    @(negedge clk);
    start = 1'b0; dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'h55AA_55AA;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sd_hold%0d_req", k),  32'(dif.dmem_req), 32'h1);
      chk($sformatf("sd_hold%0d_rw", k),   32'(wb_rw), 32'h0);
      chk($sformatf("sd_hold%0d_data", k), wb_data, tbl[5].e_data);
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    chk("sd_wb_data", wb_data, 32'h55AA_55AA);
    chk("sd_wb_rd",   32'(wb_rd), 32'd9);
    chk("sd_wb_rw",   32'(wb_rw), 32'h1);
    chk("sd_req_off", 32'(dif.dmem_req), 32'h0);
    @(negedge clk);
    dif.dmem_ack = 1'b0; idle_inputs();

    // reset asserted mid-BUSY abandons the access immediately
    @(negedge clk);
    drive(32'h0000_0080, 32'h0, 5'd6, 1, 1, 1, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rb_req",     32'(dif.dmem_req), 32'h0);
    chk("rb_addr",    dif.dmem_addr, 32'h0);
    chk("rb_wb_data", wb_data, 32'h0);
    chk("rb_wb_rw",   32'(wb_rw), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; idle_inputs();
    run_vec(mk(32'h0000_0077, 32'h0, 4, 1, 0, 0, 0, 0, 32'h0, 32'h0000_0077, 4, 1, 0, 0), "post_rst");

`ifdef MEM_TIMEOUT_EN
    // no ack: abort in the 4th BUSY cycle, stall falls, sticky error
    begin
      int  stalls, fall_c;
      bit  fell;
      @(negedge clk);
      drive(32'h0000_0090, 32'h0, 5'd2, 1, 1, 1, 0);
      dif.dmem_ack = 1'b0;
      stalls = 0; fall_c = -1; fell = 0;
      for (int c = 0; c < 12 && !fell; c++) begin
        if (c > 0) @(negedge clk);
        #1;
        if (stall) stalls++;
        else if (c > 0) begin fell = 1; fall_c = c; end
        @(posedge clk);
      end
      #1;
      chk("to_stalls",  32'(stalls), 32'd4);
      chk("to_fall_c",  32'(fall_c), 32'd4);
      chk("to_err",     32'(err), 32'h1);
      chk("to_wb_rw",   32'(wb_rw), 32'h0);
      chk("to_req_off", 32'(dif.dmem_req), 32'h0);
      @(negedge clk);
      idle_inputs();
      @(posedge clk); #1;
      chk("to_err_sticky", 32'(err), 32'h1);
    end
`endif

    @(negedge clk);
    idle_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
